// File: rtl/fab_clk_reset_seq_if.sv
// fab_clk_reset_seq_if
// Groups the lock/strap/flag-clear inputs and the staged reset/status outputs
// of the fabric reset sequencer. The clock and synchronous reset stay plain
// ports on the sequencer itself.
//   FAB_LOCK      CCC lock, asynchronous to the fabric clock
//   LOCK_BYPASS   static strap, 1 = treat lock as always good
//   CLEAR_FLAGS   one-cycle pulse clearing the sticky flags
//   CORE_RESET    active-high reset for core fabric logic
//   PERIPH_RESET  active-high reset for peripherals
//   READY         high only once both resets are released
//   LOCK_LOST     sticky: lock dropped after core reset release
//   LOCK_TIMEOUT  sticky: lock never arrived within the timeout
// Modports: slave = sequencer side, master = the side driving lock/strap/clear.
interface fab_clk_reset_seq_if;
    logic FAB_LOCK;
    logic LOCK_BYPASS;
    logic CLEAR_FLAGS;
    logic CORE_RESET;
    logic PERIPH_RESET;
    logic READY;
    logic LOCK_LOST;
    logic LOCK_TIMEOUT;

    modport slave (
        input  FAB_LOCK,
        input  LOCK_BYPASS,
        input  CLEAR_FLAGS,
        output CORE_RESET,
        output PERIPH_RESET,
        output READY,
        output LOCK_LOST,
        output LOCK_TIMEOUT
    );

    modport master (
        output FAB_LOCK,
        output LOCK_BYPASS,
        output CLEAR_FLAGS,
        input  CORE_RESET,
        input  PERIPH_RESET,
        input  READY,
        input  LOCK_LOST,
        input  LOCK_TIMEOUT
    );
endinterface

// File: rtl/fab_clk_reset_seq.sv
// fab_clk_reset_seq
// Staged reset sequencer on the fabric clock. Waits for the CCC lock (or the
// bypass strap), requires it to hold for STABLE_CYCLES, releases CORE_RESET,
// then after STAGE_GAP cycles releases PERIPH_RESET and raises READY. Any
// loss of lock drops back to full reset. Sticky LOCK_LOST / LOCK_TIMEOUT flags
// report problems to firmware.
// Ports:
//   FAB_CLK    fabric clock (only clock)
//   FAB_RESET  synchronous active-high reset
//   bus        fab_clk_reset_seq_if.slave (lock, strap, flag clear, outputs)
module fab_clk_reset_seq #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic               FAB_CLK,
    input logic               FAB_RESET,
    fab_clk_reset_seq_if.slave bus
);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(STAGE_GAP - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        CORE_UP   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        sync_meta, lock_s;
    logic        started;
    logic        lock_ok;
    logic        lost_set, timeout_set;
    logic        core_reset_q, periph_reset_q, ready_q, lock_lost_q, lock_timeout_q;
    logic        core_reset_nxt, periph_reset_nxt, ready_nxt, lock_lost_nxt, lock_timeout_nxt;

    // The strap is static, so it is used directly without synchronizing.
    assign lock_ok = lock_s | bus.LOCK_BYPASS;

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            sync_meta      <= 1'b0;
            lock_s         <= 1'b0;
            started        <= 1'b0;
            state          <= WAIT_LOCK;
            cnt            <= 16'd0;
            core_reset_q   <= 1'b1;
            periph_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            sync_meta      <= bus.FAB_LOCK;
            lock_s         <= sync_meta;
            started        <= 1'b1;
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            core_reset_q   <= core_reset_nxt;
            periph_reset_q <= periph_reset_nxt;
            ready_q        <= ready_nxt;
            lock_lost_q    <= lock_lost_nxt;
            lock_timeout_q <= lock_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lost_set    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            WAIT_LOCK: begin
                // The first edge after reset release is an idle edge: the
                // FSM holds here with cnt=0, so bypass entry to STABLE and
                // the timeout count both start from edge 1.
                if (!started) begin
                    cnt_nxt = 16'd0;
                end else if (lock_ok) begin
                    state_nxt = STABLE;
                    cnt_nxt   = 16'd0;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            STABLE: begin
                if (!lock_ok) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = CORE_UP;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            CORE_UP: begin
                if (!lock_ok) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                    lost_set  = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RUN: begin
                if (!lock_ok) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                    lost_set  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = 16'd0;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state transition.
        core_reset_nxt   = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);
        periph_reset_nxt = (state_nxt != RUN);
        ready_nxt        = (state_nxt == RUN);

        // Setting beats a coincident clear.
        lock_lost_nxt    = lost_set    | (lock_lost_q    & ~bus.CLEAR_FLAGS);
        lock_timeout_nxt = timeout_set | (lock_timeout_q & ~bus.CLEAR_FLAGS);
    end

    assign bus.CORE_RESET   = core_reset_q;
    assign bus.PERIPH_RESET = periph_reset_q;
    assign bus.READY        = ready_q;
    assign bus.LOCK_LOST    = lock_lost_q;
    assign bus.LOCK_TIMEOUT = lock_timeout_q;
endmodule

// File: tb/tb_fab_clk_reset_seq.sv
// tb_fab_clk_reset_seq
// Bench for fab_clk_reset_seq with STABLE_CYCLES=8, STAGE_GAP=4,
// TIMEOUT_CYCLES=20. The reference model tracks run lengths of good and bad
// lock samples instead of FSM states: core reset releases after S+1
// consecutive good samples, peripherals after S+G+1, a bad sample after at
// least S+1 good ones flags lock loss, and T+1 consecutive bad samples flag
// a timeout. The first edge after reset release counts as a bad sample.
module tb_fab_clk_reset_seq;
    localparam int S = 8;
    localparam int G = 4;
    localparam int T = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fab_clk_reset_seq_if bus();

    fab_clk_reset_seq #(
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .FAB_CLK  (clk),
        .FAB_RESET(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int hold  = 0;

    // Reference model state
    bit hist[$] = '{1'b0, 1'b0};
    int good_run = 0;
    int bad_run  = 0;
    bit fresh    = 1'b1;
    bit m_lost   = 1'b0;
    bit m_to     = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit ok;
        bit lost_set;
        bit to_set;
        if (rst) begin
            hist     = '{1'b0, 1'b0};
            good_run = 0;
            bad_run  = 0;
            fresh    = 1'b1;
            m_lost   = 1'b0;
            m_to     = 1'b0;
        end else begin
            // hist[1] is FAB_LOCK as it was two edges ago.
            ok = !fresh && (hist[1] || bus.LOCK_BYPASS);
            hist.push_front(bus.FAB_LOCK);
            void'(hist.pop_back());
            lost_set = 1'b0;
            to_set   = 1'b0;
            if (ok) begin
                if (good_run < 100000) good_run++;
                bad_run = 0;
            end else begin
                lost_set = (good_run >= S + 1);
                good_run = 0;
                if (bad_run < 100000) bad_run++;
                to_set = (bad_run >= T + 1);
            end
            m_lost = lost_set || (m_lost && !bus.CLEAR_FLAGS);
            m_to   = to_set   || (m_to   && !bus.CLEAR_FLAGS);
            fresh  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        edge_n++;
        chk("core_reset",   bus.CORE_RESET,   !(good_run >= S + 1));
        chk("periph_reset", bus.PERIPH_RESET, !(good_run >= S + G + 1));
        chk("ready",        bus.READY,        (good_run >= S + G + 1));
        chk("lock_lost",    bus.LOCK_LOST,    m_lost);
        chk("lock_timeout", bus.LOCK_TIMEOUT, m_to);
        chk("release_order", (!bus.PERIPH_RESET && bus.CORE_RESET), 1'b0);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        edge_n = -1;
    endtask

    initial begin
        bus.FAB_LOCK    = 1'b0;
        bus.LOCK_BYPASS = 1'b0;
        bus.CLEAR_FLAGS = 1'b0;
        #2;

        // Normal release with lock high from edge 0
        bus.FAB_LOCK = 1'b1;
        apply_reset();
        chk("reset_core", bus.CORE_RESET, 1'b1);
        chk("reset_ready", bus.READY, 1'b0);
        run_to(9);
        chk("core_hold_e9", bus.CORE_RESET, 1'b1);
        run_to(10);
        chk("core_fall_e10", bus.CORE_RESET, 1'b0);
        chk("periph_hold_e10", bus.PERIPH_RESET, 1'b1);
        run_to(13);
        chk("ready_low_e13", bus.READY, 1'b0);
        run_to(14);
        chk("ready_rise_e14", bus.READY, 1'b1);
        chk("periph_fall_e14", bus.PERIPH_RESET, 1'b0);
        chk("no_lost_e14", bus.LOCK_LOST, 1'b0);
        chk("no_timeout_e14", bus.LOCK_TIMEOUT, 1'b0);

        // Lock loss in RUN, then recovery
        run_to(20);
        bus.FAB_LOCK = 1'b0;
        run_to(22);
        chk("ready_still_e22", bus.READY, 1'b1);
        run_to(23);
        chk("loss_core_e23", bus.CORE_RESET, 1'b1);
        chk("loss_periph_e23", bus.PERIPH_RESET, 1'b1);
        chk("loss_ready_e23", bus.READY, 1'b0);
        chk("loss_flag_e23", bus.LOCK_LOST, 1'b1);
        bus.FAB_LOCK = 1'b1;
        run_to(33);
        chk("rec_core_hold_e33", bus.CORE_RESET, 1'b1);
        run_to(34);
        chk("rec_core_fall_e34", bus.CORE_RESET, 1'b0);
        run_to(38);
        chk("rec_ready_e38", bus.READY, 1'b1);
        chk("rec_lost_sticky", bus.LOCK_LOST, 1'b1);
        bus.CLEAR_FLAGS = 1'b1;
        tick();
        bus.CLEAR_FLAGS = 1'b0;
        chk("lost_cleared", bus.LOCK_LOST, 1'b0);

        // Lock timeout
        bus.FAB_LOCK = 1'b0;
        apply_reset();
        run_to(19);
        chk("timeout_low_e19", bus.LOCK_TIMEOUT, 1'b0);
        run_to(20);
        chk("timeout_set_e20", bus.LOCK_TIMEOUT, 1'b1);
        chk("timeout_core", bus.CORE_RESET, 1'b1);
        run_to(25);
        bus.CLEAR_FLAGS = 1'b1;
        tick();
        bus.CLEAR_FLAGS = 1'b0;
        chk("timeout_set_wins", bus.LOCK_TIMEOUT, 1'b1);
        run_to(30);
        bus.FAB_LOCK = 1'b1;
        run_to(41);
        chk("late_core_fall_e41", bus.CORE_RESET, 1'b0);
        run_to(45);
        chk("late_ready_e45", bus.READY, 1'b1);
        chk("timeout_sticky", bus.LOCK_TIMEOUT, 1'b1);
        bus.CLEAR_FLAGS = 1'b1;
        tick();
        bus.CLEAR_FLAGS = 1'b0;
        chk("timeout_cleared", bus.LOCK_TIMEOUT, 1'b0);

        // One-cycle lock glitch in STABLE restarts the count
        bus.FAB_LOCK = 1'b1;
        apply_reset();
        run_to(5);
        bus.FAB_LOCK = 1'b0;
        tick();
        bus.FAB_LOCK = 1'b1;
        run_to(16);
        chk("glitch_core_hold_e16", bus.CORE_RESET, 1'b1);
        run_to(17);
        chk("glitch_core_fall_e17", bus.CORE_RESET, 1'b0);
        chk("glitch_no_lost", bus.LOCK_LOST, 1'b0);

        // Bypass strap with lock tied low
        bus.FAB_LOCK    = 1'b0;
        bus.LOCK_BYPASS = 1'b1;
        apply_reset();
        run_to(8);
        chk("byp_core_hold_e8", bus.CORE_RESET, 1'b1);
        run_to(9);
        chk("byp_core_fall_e9", bus.CORE_RESET, 1'b0);
        run_to(12);
        chk("byp_ready_low_e12", bus.READY, 1'b0);
        run_to(13);
        chk("byp_ready_e13", bus.READY, 1'b1);
        run_to(15);
        bus.LOCK_BYPASS = 1'b0;
        tick();
        chk("byp_drop_lost", bus.LOCK_LOST, 1'b1);
        chk("byp_drop_core", bus.CORE_RESET, 1'b1);
        bus.LOCK_BYPASS = 1'b1;

        // Reset asserted in CORE_UP
        run_to(26);
        chk("coreup_core", bus.CORE_RESET, 1'b0);
        chk("coreup_periph", bus.PERIPH_RESET, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_core", bus.CORE_RESET, 1'b1);
        chk("midrst_periph", bus.PERIPH_RESET, 1'b1);
        chk("midrst_lost", bus.LOCK_LOST, 1'b0);

        // Clear coinciding with a lock loss in RUN
        bus.LOCK_BYPASS = 1'b0;
        bus.FAB_LOCK    = 1'b1;
        rst = 1'b0;
        edge_n = -1;
        run_to(16);
        bus.FAB_LOCK = 1'b0;
        run_to(18);
        chk("pre_clr_ready", bus.READY, 1'b1);
        bus.CLEAR_FLAGS = 1'b1;
        tick();
        bus.CLEAR_FLAGS = 1'b0;
        chk("clr_vs_set_lost", bus.LOCK_LOST, 1'b1);
        chk("clr_vs_set_ready", bus.READY, 1'b0);
        bus.FAB_LOCK = 1'b1;
        run_to(40);

        // Randomized phase against the model
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                bus.FAB_LOCK = ($urandom_range(0, 99) < 75);
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 299) == 0) bus.LOCK_BYPASS = ~bus.LOCK_BYPASS;
            bus.CLEAR_FLAGS = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        bus.CLEAR_FLAGS = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
